patch_eval_arb: RTL and testbench
=================================

PATCH_EVAL_ARB -- requirements
Module: patch_eval_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the patch evaluator; legal range 2..16.
REQ-002 Parameter W, default 8: bit width of each operand vector and of the result.
REQ-003 Derived constant IDW = clog2(NREQ): requester-id width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, NREQ: bit i = requester i presents an operand set.
REQ-007 Port req_ready, output, NREQ: bit i = requester i's operand set is accepted this cycle.
REQ-008 Ports req_a, req_b, req_c, input, NREQ*W each: operand slice i occupies bits [i*W +: W].
REQ-009 Port rsp_valid, output, 1: response register holds a valid result.
REQ-010 Port rsp_ready, input, 1: consumer accepts the response this cycle.
REQ-011 Port rsp_id, output, IDW: index of the requester that owns the response.
REQ-012 Port rsp_t, output, W: patched result vector.
REQ-013 Port done_cnt, output, 16: count of completed responses.
REQ-014 Port busy, output, 1: high when either pipeline stage is valid.

Function
REQ-015 Result: rsp_t = a | (b & c), bitwise over W bits, for the accepted operand set.
REQ-016 Pipeline: stage S1 (operand register plus id) feeds stage S2 (result register driving rsp_*); each stage has its own valid bit.
REQ-017 Stall rules: s2_load = !rsp_valid | rsp_ready; s1_free = !s1_valid | s2_load.
REQ-018 Arbitration: round-robin from pointer ptr; winner = first i with req_valid[i] set, searching ptr, ptr+1, ..., mod NREQ.
REQ-019 req_ready[i] is high only for the winner, and only when s1_free; all other bits are 0.
REQ-020 Accept: req_valid[i] & req_ready[i] loads S1 with operands and id i; ptr becomes (i+1) mod NREQ.
REQ-021 No accept in a cycle: ptr holds its value.
REQ-022 Latency: a request accepted in cycle k drives rsp_valid in cycle k+2 when rsp_ready stays high.
REQ-023 Throughput: one response per cycle while requests are pending and rsp_ready is high.
REQ-024 Backpressure (rsp_valid & !rsp_ready): rsp_valid, rsp_id and rsp_t stay stable and S2 holds.
REQ-025 Backpressure: S1 holds if valid; at most 2 requests are in flight; no request is lost or duplicated.
REQ-026 A response transfers on rsp_valid & rsp_ready; in that same cycle S2 reloads from S1 if S1 is valid, else rsp_valid drops.
REQ-027 done_cnt increments by 1 per response transfer and wraps from 0xFFFF to 0x0000.
REQ-028 A requester must hold req_valid and its operands stable until accepted; the block does not check this.

Reset
REQ-029 When rst is high at a clock edge: s1_valid=0, rsp_valid=0, rsp_id=0, rsp_t=0, ptr=0, done_cnt=0.
REQ-030 While rst is high, req_ready is all 0 and busy is 0.
REQ-031 Reset mid-operation discards all in-flight work; no response from before reset appears afterwards.

Structure
REQ-032 Shared package patch_eval_pkg holds: NREQ/W defaults, the IDW function, and the patch function f(a,b,c) = a | (b & c).
REQ-033 Sub-module patch_eval_core is the combinational W-bit evaluator instantiated between S1 and S2.
REQ-034 The arbiter, pointer and stall logic are in patch_eval_arb; target size is 120-400 RTL lines.

Verification
REQ-035 Single request: req 0 with a=0x00, b=0x0F, c=0x3C, accepted in cycle k -> rsp_valid in cycle k+2, rsp_id=0, rsp_t=0x0C, done_cnt=1.
REQ-036 All 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,... with one response per cycle.
REQ-037 Only req 2 and req 3 valid, ptr=3 -> req 3 granted first, then req 2, then req 3.
REQ-038 rsp_ready=0 for 5 cycles with 4 requesters active -> rsp_* stable, req_ready all 0 once S1 is full, all responses delivered in order after release.
REQ-039 rst pulsed for 1 cycle with S1 and S2 full -> next cycle rsp_valid=0, busy=0, ptr=0, done_cnt=0; no stale response afterwards.
REQ-040 65536 completed responses -> done_cnt reads 0xFFFF after the 65535th response and 0x0000 after the 65536th.

Source files
------------

// File: rtl/patch_eval_pkg.sv
// Shared defaults and helpers for the patch evaluator arbiter.
// The patch function is evaluated at a fixed wide width and narrowed by the caller.
package patch_eval_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int PW       = 64;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [PW-1:0] patch_f(
        input logic [PW-1:0] a,
        input logic [PW-1:0] b,
        input logic [PW-1:0] c
    );
        return a | (b & c);
    endfunction

endpackage

// File: rtl/patch_eval_arb_if.sv
// Requester and response bundle of the patch evaluator arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface patch_eval_arb_if
    import patch_eval_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
);
    localparam int IDW = idw(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*W-1:0] req_c;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_t;
    logic [15:0]       done_cnt;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_t, done_cnt, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_t, done_cnt, busy
    );

endinterface

// File: rtl/patch_eval_core.sv
// Combinational W-bit patch evaluator: t = a | (b & c).
// W is limited to the package evaluation width PW.
module patch_eval_core
    import patch_eval_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] t
);

    assign t = W'(patch_f(PW'(a), PW'(b), PW'(c)));

endmodule

// File: rtl/patch_eval_arb.sv
// Round-robin arbiter feeding a two-stage patch evaluation pipeline.
// S1 holds the granted operands, S2 holds the result driving rsp_*.
module patch_eval_arb
    import patch_eval_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input logic             clk,
    input logic             rst,
    patch_eval_arb_if.slave bus
);

    localparam int IDW = idw(NREQ);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           found;
    int             idx;

    logic           s1_valid;
    logic [IDW-1:0] s1_id;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic [W-1:0]   s1_c;
    logic [W-1:0]   s1_t;

    logic           s2_load;
    logic           s1_free;
    logic           accept;

    assign s2_load = !bus.rsp_valid || bus.rsp_ready;
    assign s1_free = !s1_valid || s2_load;
    assign accept  = found && s1_free && !rst;
    assign bus.busy = (s1_valid || bus.rsp_valid) && !rst;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        bus.req_ready = '0;
        if (accept) bus.req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            ptr      <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_id    <= win;
            s1_a     <= bus.req_a[int'(win)*W +: W];
            s1_b     <= bus.req_b[int'(win)*W +: W];
            s1_c     <= bus.req_c[int'(win)*W +: W];
            ptr      <= ptr_nxt;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    patch_eval_core #(
        .W(W)
    ) u_core (
        .a(s1_a),
        .b(s1_b),
        .c(s1_c),
        .t(s1_t)
    );

    // S2 only advances when empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_t     <= '0;
            bus.done_cnt  <= '0;
        end else begin
            if (s2_load) begin
                bus.rsp_valid <= s1_valid;
                if (s1_valid) begin
                    bus.rsp_id <= s1_id;
                    bus.rsp_t  <= s1_t;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready)
                bus.done_cnt <= bus.done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_patch_eval_arb.sv
// Self-checking bench for patch_eval_arb against a queue-based reference model.
module tb_patch_eval_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    patch_eval_arb_if #(.NREQ(NREQ), .W(W)) bus ();

    patch_eval_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int           id;
        logic [W-1:0] t;
        bit           in_s2;
    } ent_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] t;
    } vec_t;

    ent_t q[$];
    int   m_ptr;
    int   m_done;
    int   n_chk;
    int   n_fail;
    int   acc;
    int   seen_rsp;
    bit   seen_rv;
    logic [NREQ-1:0] seen_ready;
    logic [1:0]      seen_id;
    logic [W-1:0]    seen_t;
    vec_t tv[6];

    function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] op(logic [NREQ*W-1:0] v, int i);
        return v[i*W +: W];
    endfunction

    function automatic logic [W-1:0] ref_t(int i);
        return op(bus.req_a, i) | (op(bus.req_b, i) & op(bus.req_c, i));
    endfunction

    task automatic set_req(int i, bit v, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        bus.req_valid[i]    = v;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_c[i*W +: W] = c;
    endtask

    task automatic set_rand(int i);
        set_req(i, 1'b1, W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Called at a negedge with inputs applied; compares, advances model, waits next negedge.
    task automatic tick();
        bit e_rv;
        bit e_load;
        bit free;
        bit s1_full;
        int e_win;
        logic [NREQ-1:0] e_ready;
        #1;
        e_rv    = (q.size() > 0) && q[0].in_s2;
        s1_full = (q.size() > 0) && !q[q.size()-1].in_s2;
        e_load  = !e_rv || bus.rsp_ready;
        free    = !s1_full || e_load;
        e_win   = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (e_win < 0 && bus.req_valid[i]) e_win = i;
        end
        e_ready = '0;
        if (!rst && free && e_win >= 0) e_ready[e_win] = 1'b1;

        seen_ready = bus.req_ready;
        seen_rv    = bus.rsp_valid;
        seen_id    = bus.rsp_id;
        seen_t     = bus.rsp_t;
        seen_rsp   = (bus.rsp_valid && bus.rsp_ready) ? int'(bus.rsp_id) : -1;

        cmp("req_ready", bus.req_ready, e_ready);
        cmp("rsp_valid", bus.rsp_valid, e_rv);
        if (e_rv) begin
            cmp("rsp_id", bus.rsp_id, q[0].id);
            cmp("rsp_t", bus.rsp_t, q[0].t);
        end
        cmp("busy", bus.busy, !rst && q.size() > 0);
        cmp("done_cnt", bus.done_cnt, m_done & 32'hFFFF);

        acc = -1;
        if (rst) begin
            q.delete();
            m_ptr  = 0;
            m_done = 0;
        end else begin
            if (e_ready != 0) acc = e_win;
            if (e_rv && bus.rsp_ready) begin
                void'(q.pop_front());
                m_done++;
            end
            if (e_load) foreach (q[j]) q[j].in_s2 = 1'b1;
            if (acc >= 0) begin
                q.push_back('{id: acc, t: ref_t(acc), in_s2: 1'b0});
                m_ptr = (acc + 1) % NREQ;
            end
        end
        @(negedge clk);
    endtask

    task automatic after_acc(bit keep);
        if (acc >= 0) begin
            if (keep) set_rand(acc);
            else bus.req_valid[acc] = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic all_valid();
        for (int i = 0; i < NREQ; i++) set_rand(i);
    endtask

    initial begin
        int nexp;
        n_chk  = 0;
        n_fail = 0;
        m_ptr  = 0;
        m_done = 0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;
        bus.rsp_ready = 1'b1;

        tv[0] = '{id: 0, a: 8'h00, b: 8'h0F, c: 8'h3C, t: 8'h0C};
        tv[1] = '{id: 1, a: 8'hFF, b: 8'h00, c: 8'h00, t: 8'hFF};
        tv[2] = '{id: 2, a: 8'h00, b: 8'hAA, c: 8'hCC, t: 8'h88};
        tv[3] = '{id: 3, a: 8'hA5, b: 8'h5A, c: 8'hFF, t: 8'hFF};
        tv[4] = '{id: 1, a: 8'h10, b: 8'hF0, c: 8'h0F, t: 8'h10};
        tv[5] = '{id: 2, a: 8'h00, b: 8'h00, c: 8'hFF, t: 8'h00};

        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        cmp("rst_rsp_valid", bus.rsp_valid, 0);
        cmp("rst_rsp_id", bus.rsp_id, 0);
        cmp("rst_rsp_t", bus.rsp_t, 0);
        cmp("rst_busy", bus.busy, 0);
        cmp("rst_done", bus.done_cnt, 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 2; i++) tick();
            set_req(tv[v].id, 1'b1, tv[v].a, tv[v].b, tv[v].c);
            tick();
            cmp("tv_accept", seen_ready, 1 << tv[v].id);
            bus.req_valid[tv[v].id] = 1'b0;
            tick();
            cmp("tv_k1_idle", seen_rv, 0);
            tick();
            cmp("tv_k2_valid", seen_rv, 1);
            cmp("tv_k2_id", seen_id, tv[v].id);
            cmp("tv_k2_t", seen_t, tv[v].t);
            tick();
            if (v == 0) cmp("tv_done1", bus.done_cnt, 1);
        end

        do_reset();
        all_valid();
        for (int c = 0; c < 14; c++) begin
            tick();
            after_acc(1'b1);
            if (c >= 2) cmp("rr_seq", seen_rsp, (c - 2) % NREQ);
        end

        do_reset();
        set_rand(2);
        tick();
        after_acc(1'b0);
        set_rand(2);
        set_rand(3);
        tick();
        cmp("ptr3_first", seen_ready, 4'b1000);
        after_acc(1'b1);
        tick();
        cmp("ptr3_second", seen_ready, 4'b0100);
        after_acc(1'b1);
        tick();
        cmp("ptr3_third", seen_ready, 4'b1000);
        after_acc(1'b1);

        do_reset();
        all_valid();
        nexp = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            after_acc(1'b1);
        end
        bus.rsp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            after_acc(1'b1);
            cmp("bp_ready0", seen_ready, 0);
            cmp("bp_rsp_valid", seen_rv, 1);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            after_acc(1'b1);
            if (seen_rsp >= 0) begin
                cmp("bp_order", seen_rsp, nexp);
                nexp = (nexp + 1) % NREQ;
            end
        end

        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            after_acc(1'b1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        all_valid();
        bus.rsp_ready = 1'b1;
        #1;
        cmp("prst_rsp_valid", bus.rsp_valid, 0);
        cmp("prst_busy", bus.busy, 0);
        cmp("prst_done", bus.done_cnt, 0);
        cmp("prst_rsp_t", bus.rsp_t, 0);
        cmp("prst_ptr0", bus.req_ready, 4'b0001);
        for (int c = 0; c < 8; c++) begin
            tick();
            after_acc(1'b1);
        end

        for (int c = 0; c < 3000; c++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            after_acc(1'b0);
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) set_rand(i);
        end
        rst = 1'b0;

        do_reset();
        all_valid();
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 70000 && m_done < 65535; c++) begin
            tick();
            after_acc(1'b1);
        end
        cmp("wrap_ffff", bus.done_cnt, 16'hFFFF);
        tick();
        after_acc(1'b1);
        cmp("wrap_zero", bus.done_cnt, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
